conv1d_mf: RTL and testbench
============================

// Module: conv1d_mf
// PURPOSE
//  Multi-filter, multi-channel 1D convolution layer for the wake-word datapath. Buffers one frame of
//  COLUMN_LEN-channel int8 columns, then per time step computes NUM_FILTERS outputs:
//  FILTER_LEN-tap MAC + bias + ReLU + shift/saturate. Emits one NUM_FILTERS-wide int8 column per step.
//  Weights/bias live in internal register files written through a config port. Sits between MFCC/previous
//  conv stage and the next conv/dense stage.
// PARAMETERS
//  FRAME_LEN    50  columns per frame (>= FILTER_LEN)
//  COLUMN_LEN   13  input channels per column
//  NUM_FILTERS  8   output channels
//  FILTER_LEN   3   taps (odd, >=1); "same" zero padding of (FILTER_LEN-1)/2 each side
//  SHIFT        8   quantization right-shift applied after ReLU
// PORTS
//  clk_i         in   1                   clock
//  rst_n_i       in   1                   synchronous active-low reset
//  data_i        in   COLUMN_LEN*8        input column, element c at [8c+7:8c], signed
//  valid_i       in   1                   input valid
//  last_i        in   1                   final column of frame
//  ready_o       out  1                   input ready
//  data_o        out  NUM_FILTERS*8       output column, filter f at [8f+7:8f], signed (0..127)
//  valid_o       out  1                   output valid
//  last_o        out  1                   final output column of frame
//  ready_i       in   1                   downstream ready
//  wt_wr_en_i    in   1                   weight write strobe
//  wt_addr_i     in   clog2(NUM_FILTERS*FILTER_LEN)  address = f*FILTER_LEN + k
//  wt_data_i     in   COLUMN_LEN*8        signed weights for filter f, tap k, all channels
//  bias_wr_en_i  in   1                   bias write strobe
//  bias_addr_i   in   clog2(NUM_FILTERS)  filter index
//  bias_data_i   in   16                  signed bias
// BEHAVIOUR
//  Reset: state=LOAD, counters 0, valid_o=0, last_o=0, data_o=0, ready_o=1, weights/bias/frame buffer=0.
//  Handshake: transfer on valid&ready; valid_o/data_o/last_o held stable until ready_i.
//  LOAD: ready_o=1; accepted column stored at index cnt, cnt++. Frame closes when last_i accepted or
//   cnt reaches FRAME_LEN-1 accepted (whichever first). Early last_i: unfilled columns read as zero.
//   Close -> COMPUTE, ready_o=0 next cycle.
//  COMPUTE: for output t, one tap k per cycle (FILTER_LEN cycles); input index t+k-(FILTER_LEN-1)/2,
//   out-of-range -> zero. All filters/channels in parallel. acc clears at k=0. -> EMIT.
//  EMIT: valid_o=1; on accept: t==FRAME_LEN-1 -> LOAD (cnt=0), else t++ -> COMPUTE.
//   last_o=1 only for t==FRAME_LEN-1.
//  Latency: first valid_o FILTER_LEN+1 cycles after frame-closing beat; throughput 1 column
//   per FILTER_LEN+1 cycles when ready_i=1.
//  Arithmetic: product int8*int8 -> 16b signed; acc width 16+clog2(FILTER_LEN*COLUMN_LEN)+1 b,
//   no overflow possible. y = acc + sign_ext(bias); y<0 -> 0; y >>= SHIFT (logical, y>=0);
//   y>127 -> 127.
//  Config writes: accepted only in LOAD; ignored in COMPUTE/EMIT. Simultaneous weight+bias write both
//   take effect. Write and read same cycle in LOAD: new value visible next cycle.
//  Reset mid-frame: partial frame and pending output discarded, returns to reset state next cycle.
//  Backpressure: ready_i=0 in EMIT stalls indefinitely, no data loss.
// TESTING
//  1. FILTER_LEN=3, all weights 1, bias 0, SHIFT 0, COLUMN_LEN=1, input 1..50 -> out[0]=3,
//     out[t]=3t+3, out[49]=99; last_o on 50th.
//  2. Bias -1000, weights 1, input all 10 -> every output 0 (ReLU).
//  3. Weights 127, input all 127, COLUMN_LEN=13, SHIFT 8 -> interior 127 (saturated); edges also
//     checked vs model.
//  4. last_i on 10th column -> columns 10..49 treated zero; 50 outputs; last_o on 50th.
//  5. ready_i toggled random 50% -> outputs identical to ready_i=1 run, valid_o/data_o stable while
//     stalled.
//  6. Weight write during COMPUTE ignored; rst_n_i low mid-LOAD -> valid_o=0, ready_o=1, next frame
//     correct.

Source files
------------

// File: rtl/conv1d_mf.sv
// ---------------------------------------------------------------------------
// conv1d_mf
// Multi-filter, multi-channel 1D convolution layer for the wake-word datapath.
// A frame of int8 columns is buffered first. For each time step t the block
// then computes all NUM_FILTERS outputs in parallel. It walks the FILTER_LEN
// taps one per cycle, adds the bias, applies ReLU, shifts right by SHIFT and
// saturates to 127. One NUM_FILTERS-wide int8 column is emitted per step.
//
// Ports
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   data_i/valid_i/     input column stream (channel c at [8c+7:8c]),
//   last_i/ready_o      last_i closes the frame early
//   data_o/valid_o/     output column stream (filter f at [8f+7:8f]),
//   last_o/ready_i      last_o marks output column FRAME_LEN-1
//   wt_wr_en_i/         weight row write, address f*FILTER_LEN + k,
//   wt_addr_i/wt_data_i one signed int8 per channel
//   bias_wr_en_i/       per-filter signed 16-bit bias write
//   bias_addr_i/bias_data_i
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. A source never drops valid or changes data/last while ready is low.
// Config writes land only while the block is loading (ready_o high).
// ---------------------------------------------------------------------------
module conv1d_mf #(
  parameter int FRAME_LEN   = 50,
  parameter int COLUMN_LEN  = 13,
  parameter int NUM_FILTERS = 8,
  parameter int FILTER_LEN  = 3,
  parameter int SHIFT       = 8,
  localparam int WT_AW = (NUM_FILTERS * FILTER_LEN > 1) ? $clog2(NUM_FILTERS * FILTER_LEN) : 1,
  localparam int BS_AW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [COLUMN_LEN*8-1:0]    data_i,
  input  logic                       valid_i,
  input  logic                       last_i,
  output logic                       ready_o,
  output logic [NUM_FILTERS*8-1:0]   data_o,
  output logic                       valid_o,
  output logic                       last_o,
  input  logic                       ready_i,
  input  logic                       wt_wr_en_i,
  input  logic [WT_AW-1:0]           wt_addr_i,
  input  logic [COLUMN_LEN*8-1:0]    wt_data_i,
  input  logic                       bias_wr_en_i,
  input  logic [BS_AW-1:0]           bias_addr_i,
  input  logic [15:0]                bias_data_i
);

  localparam int NUM_WT = NUM_FILTERS * FILTER_LEN;
  localparam int PAD    = (FILTER_LEN - 1) / 2;
  localparam int ACC_W  = 16 + $clog2(FILTER_LEN * COLUMN_LEN) + 1;
  localparam int Y_W    = ACC_W + 1;
  localparam int CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int K_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [COLUMN_LEN*8-1:0]  r_buf  [FRAME_LEN];
  logic [COLUMN_LEN*8-1:0]  r_wt   [NUM_WT];
  logic [15:0]              r_bias [NUM_FILTERS];
  logic signed [ACC_W-1:0]  r_acc  [NUM_FILTERS];
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         r_len;   // columns actually received this frame
  logic [CNT_W-1:0]         r_t;
  logic [K_W-1:0]           r_k;
  logic [NUM_FILTERS*8-1:0] r_data;

  logic w_in_fire, w_close, w_out_fire, w_last_tap, w_last_col;

  assign ready_o    = (r_state == S_LOAD);
  assign valid_o    = (r_state == S_EMIT);
  assign w_last_col = (r_t == CNT_W'(FRAME_LEN - 1));
  assign last_o     = valid_o && w_last_col;
  assign data_o     = r_data;
  assign w_in_fire  = valid_i && ready_o;
  assign w_close    = w_in_fire && (last_i || (r_cnt == CNT_W'(FRAME_LEN - 1)));
  assign w_out_fire = valid_o && ready_i;
  assign w_last_tap = (r_k == K_W'(FILTER_LEN - 1));

  // ---------------------------------------------------------------- MAC ----
  int                       w_idx;
  logic                     w_tap_ok;
  logic [COLUMN_LEN*8-1:0]  w_col;
  int                       w_wi;
  logic [COLUMN_LEN*8-1:0]  w_wrow;
  logic signed [15:0]       w_xa, w_wa, w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_acc_next [NUM_FILTERS];
  logic signed [Y_W-1:0]    w_y;
  logic [Y_W-1:0]           w_y_u;
  logic [NUM_FILTERS*8-1:0] w_result;

  always_comb begin
    w_idx    = int'(r_t) + int'(r_k) - PAD;
    // Columns past the received length (early last_i) and the "same"
    // padding on either side both read as zero.
    w_tap_ok = (w_idx >= 0) && (w_idx < int'(r_len));
    w_col    = w_tap_ok ? r_buf[w_idx[IDX_W-1:0]] : '0;
    w_wi     = 0;
    w_wrow   = '0;
    w_xa     = '0;
    w_wa     = '0;
    w_prod   = '0;
    w_sum    = '0;
    w_y      = '0;
    w_y_u    = '0;
    w_result = '0;
    for (int f = 0; f < NUM_FILTERS; f++) begin
      w_wi   = f * FILTER_LEN + int'(r_k);
      w_wrow = r_wt[w_wi[WT_AW-1:0]];
      w_sum  = '0;
      for (int c = 0; c < COLUMN_LEN; c++) begin
        w_xa   = {{8{w_col[8*c+7]}}, w_col[8*c +: 8]};
        w_wa   = {{8{w_wrow[8*c+7]}}, w_wrow[8*c +: 8]};
        w_prod = w_xa * w_wa;  // |int8*int8| <= 16384 fits in 16 bits
        w_sum  = w_sum + {{(ACC_W-16){w_prod[15]}}, w_prod};
      end
      // Tap 0 starts a fresh accumulation instead of adding to the old one.
      w_acc_next[f] = ((r_k == '0) ? '0 : r_acc[f]) + w_sum;
      w_y = {w_acc_next[f][ACC_W-1], w_acc_next[f]}
          + {{(Y_W-16){r_bias[f][15]}}, r_bias[f]};
      if (w_y[Y_W-1]) w_y_u = '0;
      else            w_y_u = w_y >> SHIFT;
      w_result[8*f +: 8] = (w_y_u > Y_W'(127)) ? 8'd127 : w_y_u[7:0];
    end
  end

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= S_LOAD;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_LOAD:    if (w_close)    w_state_next = S_COMPUTE;
      S_COMPUTE: if (w_last_tap) w_state_next = S_EMIT;
      S_EMIT:    if (w_out_fire) w_state_next = w_last_col ? S_LOAD : S_COMPUTE;
      default:                   w_state_next = S_LOAD;
    endcase
  end

  // ----------------------------------------------------------- datapath ----
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FRAME_LEN; i++)   r_buf[i]  <= '0;
      for (int i = 0; i < NUM_WT; i++)      r_wt[i]   <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) r_bias[i] <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) r_acc[i]  <= '0;
      r_cnt  <= '0;
      r_len  <= '0;
      r_t    <= '0;
      r_k    <= '0;
      r_data <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (wt_wr_en_i && (int'(wt_addr_i) < NUM_WT))
            r_wt[wt_addr_i] <= wt_data_i;
          if (bias_wr_en_i && (int'(bias_addr_i) < NUM_FILTERS))
            r_bias[bias_addr_i] <= bias_data_i;
          if (w_in_fire) begin
            r_buf[r_cnt[IDX_W-1:0]] <= data_i;
            r_cnt <= r_cnt + 1'b1;
            if (w_close) begin
              r_len <= r_cnt + 1'b1;
              r_t   <= '0;
              r_k   <= '0;
            end
          end
        end
        S_COMPUTE: begin
          for (int f = 0; f < NUM_FILTERS; f++) r_acc[f] <= w_acc_next[f];
          if (w_last_tap) begin
            r_data <= w_result;
            r_k    <= '0;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_EMIT: begin
          if (w_out_fire) begin
            if (w_last_col) r_cnt <= '0;
            else            r_t   <= r_t + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_mf.sv
module tb_conv1d_mf;

  localparam int FRAME = 50;
  localparam int COL   = 13;
  localparam int NF    = 8;
  localparam int FL    = 3;
  localparam int SH    = 8;
  localparam int WA    = $clog2(NF * FL);
  localparam int BA    = $clog2(NF);

  // ------------------------------------------------ clock / reset / DUT ----
  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [COL*8-1:0]  data_i;
  logic              valid_i, last_i, ready_o;
  logic [NF*8-1:0]   data_o;
  logic              valid_o, last_o, ready_i;
  logic              wt_wr_en_i;
  logic [WA-1:0]     wt_addr_i;
  logic [COL*8-1:0]  wt_data_i;
  logic              bias_wr_en_i;
  logic [BA-1:0]     bias_addr_i;
  logic [15:0]       bias_data_i;

  always #5 clk_i = ~clk_i;

  conv1d_mf #(.FRAME_LEN(FRAME), .COLUMN_LEN(COL), .NUM_FILTERS(NF),
              .FILTER_LEN(FL), .SHIFT(SH)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .data_i(data_i), .valid_i(valid_i), .last_i(last_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i),
    .wt_wr_en_i(wt_wr_en_i), .wt_addr_i(wt_addr_i), .wt_data_i(wt_data_i),
    .bias_wr_en_i(bias_wr_en_i), .bias_addr_i(bias_addr_i), .bias_data_i(bias_data_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: plain signed integers.
  int w_m [NF*FL][COL];
  int b_m [NF];
  int x_m [FRAME][COL];
  logic [NF*8-1:0] got_o [FRAME];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ------------------------------------------------------------ model ----
  function automatic logic [NF*8-1:0] model_col(input int t);
    logic [NF*8-1:0] r;
    int y, idx;
    r = '0;
    for (int f = 0; f < NF; f++) begin
      y = b_m[f];
      for (int k = 0; k < FL; k++) begin
        idx = t + k - (FL - 1) / 2;
        if (idx >= 0 && idx < FRAME)
          for (int c = 0; c < COL; c++) y += w_m[f*FL+k][c] * x_m[idx][c];
      end
      if (y < 0) y = 0;
      y = y / (1 << SH);
      if (y > 127) y = 127;
      r[f*8 +: 8] = 8'(y);
    end
    return r;
  endfunction

  function automatic logic [COL*8-1:0] pack_x(input int i);
    logic [COL*8-1:0] r;
    for (int c = 0; c < COL; c++) r[c*8 +: 8] = 8'(x_m[i][c]);
    return r;
  endfunction

  function automatic logic [COL*8-1:0] pack_w(input int a);
    logic [COL*8-1:0] r;
    for (int c = 0; c < COL; c++) r[c*8 +: 8] = 8'(w_m[a][c]);
    return r;
  endfunction

  // ----------------------------------------------------------- drivers ----
  task automatic clear_model();
    for (int a = 0; a < NF*FL; a++) for (int c = 0; c < COL; c++) w_m[a][c] = 0;
    for (int f = 0; f < NF; f++) b_m[f] = 0;
  endtask

  task automatic idle_inputs();
    data_i = '0; valid_i = 0; last_i = 0; ready_i = 0;
    wt_wr_en_i = 0; wt_addr_i = '0; wt_data_i = '0;
    bias_wr_en_i = 0; bias_addr_i = '0; bias_data_i = '0;
  endtask

  task automatic do_reset();
    rst_n_i = 0;
    idle_inputs();
    repeat (3) @(negedge clk_i);
    rst_n_i = 1;
    clear_model();
  endtask

  // Weight and bias rows go in together where both exist.
  task automatic load_cfg();
    for (int a = 0; a < NF*FL; a++) begin
      @(negedge clk_i);
      wt_wr_en_i = 1; wt_addr_i = WA'(a); wt_data_i = pack_w(a);
      bias_wr_en_i = (a < NF);
      bias_addr_i  = BA'(a % NF);
      bias_data_i  = 16'(b_m[a % NF]);
    end
    @(negedge clk_i);
    wt_wr_en_i = 0; bias_wr_en_i = 0;
  endtask

  task automatic rand_cfg();
    for (int a = 0; a < NF*FL; a++)
      for (int c = 0; c < COL; c++) w_m[a][c] = int'($urandom_range(15)) - 8;
    for (int f = 0; f < NF; f++) b_m[f] = int'($urandom_range(4000)) - 2000;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < FRAME; i++)
      for (int c = 0; c < COL; c++) x_m[i][c] = int'($urandom_range(255)) - 128;
  endtask

  task automatic send_frame(input int ncols, input bit with_last, input int gap_pct,
                            input bit corrupt);
    int cyc;
    for (int i = ncols; i < FRAME; i++) for (int c = 0; c < COL; c++) x_m[i][c] = 0;
    for (int i = 0; i < ncols; i++) begin
      @(negedge clk_i);
      if ($urandom_range(99) < gap_pct) begin
        valid_i = 0;
        @(negedge clk_i);
      end
      valid_i = 1; data_i = pack_x(i); last_i = with_last && (i == ncols - 1);
      cyc = 0;
      while (!ready_o && cyc < 100) begin
        @(negedge clk_i);
        cyc++;
      end
      if (!ready_o) begin
        n_checks++;
        $display("FAIL send_timeout: ready_o=%b at column %0d, required 1", ready_o, i);
        valid_i = 0;
        return;
      end
    end
    @(negedge clk_i);
    valid_i = 0; last_i = 0;
    if (with_last) begin
      n_checks++;
      if (ready_o !== 1'b0)
        $display("FAIL ready_after_close: got %b, required 0", ready_o);
      else n_pass++;
      if (corrupt) begin
        wt_wr_en_i = 1; wt_addr_i = '0; wt_data_i = ~pack_w(0);
        bias_wr_en_i = 1; bias_addr_i = '0; bias_data_i = 16'h7fff;
        @(negedge clk_i);
        wt_wr_en_i = 0; bias_wr_en_i = 0;
      end
    end
  endtask

  // Scoreboard: drains one frame of outputs with ready_i high pct% of cycles.
  task automatic collect(input int pct);
    logic [NF*8-1:0] exp_q[$];
    logic [NF*8-1:0] hold_d;
    logic hold_l, held;
    int got, cyc;
    for (int t = 0; t < FRAME; t++) exp_q.push_back(model_col(t));
    got = 0; cyc = 0; held = 0; hold_d = '0; hold_l = 0;
    while (got < FRAME && cyc < 8000) begin
      @(negedge clk_i);
      cyc++;
      if (held) begin
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== hold_d || last_o !== hold_l)
          $display("FAIL stall_stable: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   valid_o, data_o, last_o, hold_d, hold_l);
        else n_pass++;
      end
      held = 0;
      ready_i = ($urandom_range(99) < pct);
      if (valid_o === 1'b1) begin
        if (ready_i) begin
          n_checks++;
          if (data_o !== exp_q[0] || last_o !== (got == FRAME - 1))
            $display("FAIL out_col t=%0d: data=%h last=%b, required data=%h last=%b",
                     got, data_o, last_o, exp_q[0], (got == FRAME - 1));
          else n_pass++;
          got_o[got] = data_o;
          void'(exp_q.pop_front());
          got++;
        end else begin
          held = 1; hold_d = data_o; hold_l = last_o;
        end
      end
    end
    @(negedge clk_i);
    ready_i = 0;
    n_checks++;
    if (got < FRAME) $display("FAIL out_timeout: got %0d columns, required %0d", got, FRAME);
    else if (ready_o !== 1'b1) $display("FAIL ready_after_frame: got %b, required 1", ready_o);
    else n_pass++;
  endtask

  // ------------------------------------------------------------- tests ----
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (valid_o !== 1'b0 || last_o !== 1'b0 || data_o !== '0 || ready_o !== 1'b1)
      $display("FAIL reset_state: valid=%b last=%b data=%h ready=%b, required 0 0 0 1",
               valid_o, last_o, data_o, ready_o);
    else n_pass++;
  endtask

  task automatic test_ramp();
    for (int a = 0; a < NF*FL; a++) for (int c = 0; c < COL; c++) w_m[a][c] = (c == 0) ? 64 : 0;
    for (int f = 0; f < NF; f++) b_m[f] = 0;
    for (int i = 0; i < FRAME; i++)
      for (int c = 0; c < COL; c++) x_m[i][c] = (c == 0) ? i + 1 : int'($urandom_range(255)) - 128;
    load_cfg();
    send_frame(FRAME, 1, 0, 0);
    collect(100);
    // 64*(x[t-1]+x[t]+x[t+1]) >> 8 on channel 0 only.
    n_checks++;
    if (got_o[0] !== {NF{8'd0}}) $display("FAIL ramp_t0: got %h, required all 00", got_o[0]);
    else n_pass++;
    n_checks++;
    if (got_o[10] !== {NF{8'd8}}) $display("FAIL ramp_t10: got %h, required all 08", got_o[10]);
    else n_pass++;
    n_checks++;
    if (got_o[49] !== {NF{8'd24}}) $display("FAIL ramp_t49: got %h, required all 18", got_o[49]);
    else n_pass++;
  endtask

  task automatic test_relu();
    logic any;
    for (int a = 0; a < NF*FL; a++) for (int c = 0; c < COL; c++) w_m[a][c] = 1;
    for (int f = 0; f < NF; f++) b_m[f] = -1000;
    for (int i = 0; i < FRAME; i++) for (int c = 0; c < COL; c++) x_m[i][c] = 10;
    load_cfg();
    send_frame(FRAME, 1, 30, 0);
    collect(100);
    any = 0;
    for (int t = 0; t < FRAME; t++) any |= |got_o[t];
    n_checks++;
    if (any !== 1'b0) $display("FAIL relu_zero: some output nonzero, required all zero");
    else n_pass++;
  endtask

  task automatic test_saturate();
    for (int a = 0; a < NF*FL; a++) for (int c = 0; c < COL; c++) w_m[a][c] = 127;
    for (int f = 0; f < NF; f++) b_m[f] = 0;
    for (int i = 0; i < FRAME; i++) for (int c = 0; c < COL; c++) x_m[i][c] = 127;
    load_cfg();
    send_frame(FRAME, 1, 0, 0);
    collect(100);
    n_checks++;
    if (got_o[25] !== {NF{8'd127}}) $display("FAIL sat_interior: got %h, required all 7f", got_o[25]);
    else n_pass++;
  endtask

  task automatic test_early_last();
    rand_cfg();
    load_cfg();
    rand_frame();
    send_frame(10, 1, 20, 0);
    collect(100);
  endtask

  task automatic test_backpressure();
    rand_cfg();
    load_cfg();
    rand_frame();
    send_frame(FRAME, 1, 20, 0);
    collect(50);
  endtask

  task automatic test_cfg_in_compute();
    rand_cfg();
    load_cfg();
    rand_frame();
    send_frame(FRAME, 1, 0, 1);
    collect(100);
  endtask

  task automatic test_reset_mid_load();
    rand_cfg();
    load_cfg();
    rand_frame();
    send_frame(20, 0, 0, 0);
    @(negedge clk_i);
    rst_n_i = 0;
    @(negedge clk_i);
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== '0 || last_o !== 1'b0)
      $display("FAIL reset_mid_load: valid=%b ready=%b data=%h last=%b, required 0 1 0 0",
               valid_o, ready_o, data_o, last_o);
    else n_pass++;
    rst_n_i = 1;
    clear_model();
    rand_cfg();
    load_cfg();
    rand_frame();
    send_frame(FRAME, 1, 0, 0);
    collect(100);
  endtask

  task automatic test_back_to_back();
    rand_cfg();
    load_cfg();
    for (int n = 0; n < 2; n++) begin
      rand_frame();
      send_frame(FRAME, 1, 10, 0);
      collect(75);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_relu();
    test_saturate();
    test_early_last();
    test_backpressure();
    test_cfg_in_compute();
    test_reset_mid_load();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
